// File: rtl/ws2812_if.sv
// ws2812_if -- frame request and serial output bundle for ws2812_tx.
//   master (frame source): drives start, data_in; observes led_dout, busy, done
//   slave  (ws2812_tx)   : observes start, data_in; drives led_dout, busy, done
// Parameter NUM_LED sets the data_in width (NUM_LED*24 bits).
interface ws2812_if #(
    parameter int NUM_LED = 40
);
    localparam int DATA_W = NUM_LED * 24;

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              led_dout;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output data_in,
        input  led_dout,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output led_dout,
        output busy,
        output done
    );
endinterface

// File: rtl/ws2812_tx.sv
// ws2812_tx -- serialises a frame of NUM_LED 24-bit pixels onto a WS2812 chain,
// followed by a low latch gap.
//   rd_clk      : clock, all logic on rising edge
//   rst_n       : asynchronous active-low reset
//   bus (slave) : start, data_in (LED k = data_in[24k+23:24k]) in;
//                 led_dout, busy, done (one-cycle pulse) out
// Build option: define WS2812_GRB_EN to transmit each word as {G,R,B}
// instead of {R,G,B}; timing is identical either way.
//
// state     | meaning
// IDLE      | waiting for start; done pulse is issued in the first IDLE cycle
// BIT_HIGH  | high phase of the current bit (T1H_CYC or T0H_CYC cycles)
// BIT_LOW   | low remainder of the current bit, up to TBIT_CYC in total
// LATCH_GAP | led_dout held low for TRST_CYC cycles after the last bit
module ws2812_tx #(
    parameter int NUM_LED  = 40,
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63,
    parameter int TRST_CYC = 15000
) (
    input  logic     rd_clk,
    input  logic     rst_n,
    ws2812_if.slave  bus
);
    localparam int DATA_W  = NUM_LED * 24;
    localparam int CNT_MAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LIDX_W  = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    localparam logic [CNT_W-1:0]  T0H_L     = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0]  T1H_L     = CNT_W'(T1H_CYC);
    localparam logic [CNT_W-1:0]  TBIT_LAST = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0]  TRST_LAST = CNT_W'(TRST_CYC - 1);
    localparam logic [LIDX_W-1:0] LED_LAST  = LIDX_W'(NUM_LED - 1);

    typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, LATCH_GAP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cyc_cnt, cyc_n, cyc_inc;
    logic [4:0]        bit_idx, bit_n;
    logic [LIDX_W-1:0] led_idx, led_n;
    logic [DATA_W-1:0] shadow, shadow_n;
    logic              dout_q, busy_q, done_q;
    logic              dout_n, busy_n, done_n;
    logic [23:0]       tx_word;
    logic              cur_bit;
    logic [CNT_W-1:0]  high_len;

    function automatic logic [23:0] tx_order(input logic [23:0] w);
`ifdef WS2812_GRB_EN
        return {w[15:8], w[23:16], w[7:0]};
`else
        return w;
`endif
    endfunction

    assign tx_word  = tx_order(shadow[32'(led_idx) * 24 +: 24]);
    assign cur_bit  = tx_word[bit_idx];
    assign high_len = cur_bit ? T1H_L : T0H_L;
    assign cyc_inc  = cyc_cnt + CNT_W'(1);

    // Outputs are computed one cycle ahead and registered, so led_dout,
    // busy and done come straight from flops.
    always_comb begin
        state_n  = state;
        cyc_n    = cyc_cnt;
        bit_n    = bit_idx;
        led_n    = led_idx;
        shadow_n = shadow;
        dout_n   = 1'b0;
        busy_n   = 1'b1;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.start) begin
                    shadow_n = bus.data_in;
                    led_n    = '0;
                    bit_n    = 5'd23;
                    cyc_n    = '0;
                    state_n  = BIT_HIGH;
                    dout_n   = 1'b1;
                    busy_n   = 1'b1;
                end
            end
            BIT_HIGH: begin
                cyc_n = cyc_inc;
                if (cyc_inc == high_len) begin
                    state_n = BIT_LOW;
                end else begin
                    dout_n = 1'b1;
                end
            end
            BIT_LOW: begin
                if (cyc_cnt == TBIT_LAST) begin
                    cyc_n = '0;
                    if (bit_idx == 5'd0 && led_idx == LED_LAST) begin
                        state_n = LATCH_GAP;
                    end else begin
                        state_n = BIT_HIGH;
                        dout_n  = 1'b1;
                        if (bit_idx == 5'd0) begin
                            bit_n = 5'd23;
                            led_n = led_idx + LIDX_W'(1);
                        end else begin
                            bit_n = bit_idx - 5'd1;
                        end
                    end
                end else begin
                    cyc_n = cyc_inc;
                end
            end
            LATCH_GAP: begin
                if (cyc_cnt == TRST_LAST) begin
                    state_n = IDLE;
                    cyc_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cyc_n = cyc_inc;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            led_idx <= '0;
            shadow  <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_n;
            bit_idx <= bit_n;
            led_idx <= led_n;
            shadow  <= shadow_n;
            dout_q  <= dout_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.led_dout = dout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx -- scoreboard bench for ws2812_tx (NUM_LED=2, small timing).
// Each accepted start pushes the full expected led_dout waveform of the frame;
// a negedge monitor pops it when busy rises and checks the frame cycle by cycle,
// then the done cycle, and idle/reset quiet cycles in between.
// Build option WS2812_GRB_EN selects the {G,R,B} ordering in DUT and model alike.
module tb_ws2812_tx;
    localparam int NUM_LED   = 2;
    localparam int T0H       = 2;
    localparam int T1H       = 4;
    localparam int TBIT      = 6;
    localparam int TRST      = 10;
    localparam int DATA_W    = NUM_LED * 24;
    localparam int FRAME_CYC = NUM_LED * 24 * TBIT + TRST;
    localparam int PERIOD    = FRAME_CYC + 1;

    logic rd_clk;
    logic rst_n;

    ws2812_if #(.NUM_LED(NUM_LED)) bus ();

    ws2812_tx #(
        .NUM_LED (NUM_LED),
        .T0H_CYC (T0H),
        .T1H_CYC (T1H),
        .TBIT_CYC(TBIT),
        .TRST_CYC(TRST)
    ) dut (
        .rd_clk(rd_clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    int vectors    = 0;
    int miscompares = 0;
    int edge_n     = 0;
    int free_at    = 0;

    logic [FRAME_CYC-1:0] exp_q[$];

    always @(posedge rd_clk) edge_n <= edge_n + 1;

    function automatic logic [FRAME_CYC-1:0] model_wave(input logic [DATA_W-1:0] d);
        logic [FRAME_CYC-1:0] w;
        logic [23:0] word;
        logic [23:0] tx;
        int t;
        int hi;
        w = '0;
        t = 0;
        for (int k = 0; k < NUM_LED; k++) begin
            word = d[24*k +: 24];
`ifdef WS2812_GRB_EN
            tx = {word[15:8], word[23:16], word[7:0]};
`else
            tx = word;
`endif
            for (int j = 23; j >= 0; j--) begin
                hi = tx[j] ? T1H : T0H;
                for (int c = 0; c < TBIT; c++) begin
                    w[t] = (c < hi);
                    t++;
                end
            end
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // One input cycle: values are sampled at the next rising edge. The DUT
    // is idle there only if a full frame plus done cycle has elapsed.
    task automatic drive_cycle(input logic st, input logic [DATA_W-1:0] d);
        bus.start   = st;
        bus.data_in = d;
        if (st && rst_n && (edge_n + 1 >= free_at)) begin
            exp_q.push_back(model_wave(d));
            free_at = edge_n + 1 + PERIOD;
        end
        @(posedge rd_clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit scramble);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, scramble ? rand_data() : bus.data_in);
    endtask

    // Monitor
    logic [FRAME_CYC-1:0] cur;
    bit mon_active  = 0;
    bit expect_done = 0;
    int mon_idx     = 0;
    int bad_cnt     = 0;
    int first_bad   = -1;

    always @(negedge rd_clk) begin
        if (!rst_n) begin
            vectors++;
            if (bus.led_dout !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: led=%b busy=%b done=%b required 0 0 0",
                         bus.led_dout, bus.busy, bus.done);
            end
            mon_active  = 0;
            expect_done = 0;
        end else begin
            if (!mon_active) begin
                if (expect_done) begin
                    vectors++;
                    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.led_dout !== 1'b0) begin
                        miscompares++;
                        $display("FAIL done_cycle: done=%b busy=%b led=%b required 1 0 0",
                                 bus.done, bus.busy, bus.led_dout);
                    end
                    expect_done = 0;
                end else if (bus.busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: busy=1 required 0 (no start accepted)");
                    end else begin
                        cur        = exp_q.pop_front();
                        mon_active = 1;
                        mon_idx    = 0;
                        bad_cnt    = 0;
                        first_bad  = -1;
                    end
                end else begin
                    vectors++;
                    if (bus.led_dout !== 1'b0 || bus.done !== 1'b0) begin
                        miscompares++;
                        $display("FAIL idle_quiet: led=%b done=%b required 0 0",
                                 bus.led_dout, bus.done);
                    end
                end
            end
            if (mon_active) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.led_dout !== cur[mon_idx]) begin
                    if (first_bad < 0) begin
                        first_bad = mon_idx;
                        $display("FAIL frame_cycle %0d: led=%b busy=%b done=%b required led=%b busy=1 done=0",
                                 mon_idx, bus.led_dout, bus.busy, bus.done, cur[mon_idx]);
                    end
                    bad_cnt++;
                end
                mon_idx++;
                if (mon_idx == FRAME_CYC) begin
                    vectors++;
                    if (bad_cnt != 0) begin
                        miscompares++;
                        $display("FAIL frame: %0d bad cycles (first at %0d) required 0", bad_cnt, first_bad);
                    end
                    mon_active  = 0;
                    expect_done = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        int n;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
        idle_cycles(3, 1'b0);
        rst_n = 1'b1;
        idle_cycles(20, 1'b1);

        // Directed pattern: MSB and LSB of LED0 set, LED1 all zero.
        d = '0;
        d[23:0] = 24'h800001;
        drive_cycle(1'b1, d);
        idle_cycles(PERIOD + 3, 1'b1);

        // Single colour channel exercises the channel ordering.
        d = '0;
        d[23:0] = 24'hFF0000;
        drive_cycle(1'b1, d);
        idle_cycles(PERIOD + 2, 1'b1);

        // Second start mid-frame with new data must be ignored.
        drive_cycle(1'b1, rand_data());
        idle_cycles(49, 1'b1);
        drive_cycle(1'b1, rand_data());
        idle_cycles(PERIOD, 1'b1);

        // Random frames with random gaps and stray starts while busy.
        for (int f = 0; f < 5; f++) begin
            drive_cycle(1'b1, rand_data());
            n = $urandom_range(PERIOD + 4, 40);
            for (int i = 0; i < n; i++)
                drive_cycle(($urandom_range(0, 15) == 0), rand_data());
        end
        idle_cycles(PERIOD + 2, 1'b1);

        // Start held high: frames back-to-back on every done cycle.
        for (int i = 0; i < 3 * PERIOD + 5; i++) drive_cycle(1'b1, rand_data());
        idle_cycles(PERIOD + 2, 1'b1);

        // Reset in the middle of a frame: immediate quiet outputs, no done.
        drive_cycle(1'b1, rand_data());
        idle_cycles(99, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        free_at = 0;
        #1;
        vectors++;
        if (bus.led_dout !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: led=%b busy=%b done=%b required 0 0 0",
                     bus.led_dout, bus.busy, bus.done);
        end
        @(posedge rd_clk);
        #1;
        idle_cycles(2, 1'b1);
        rst_n = 1'b1;
        idle_cycles(5, 1'b1);
        drive_cycle(1'b1, rand_data());
        idle_cycles(PERIOD + 2, 1'b1);

        // Drain: everything pushed must have been observed.
        n = 0;
        while ((exp_q.size() != 0 || mon_active || expect_done) && n < 1000) begin
            idle_cycles(1, 1'b0);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || mon_active || expect_done) begin
            miscompares++;
            $display("FAIL drain: %0d frames outstanding required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 Parameter NUM_LED, default 40, number of LEDs per frame; data width DATA_W = NUM_LED*24.
REQ-002 Parameter T0H_CYC, default 20, rd_clk cycles high for a '0' bit.
REQ-003 Parameter T1H_CYC, default 40, rd_clk cycles high for a '1' bit.
REQ-004 Parameter TBIT_CYC, default 63, rd_clk cycles per bit period; constraint T0H_CYC < T1H_CYC < TBIT_CYC.
REQ-005 Parameter TRST_CYC, default 15000, rd_clk cycles of low latch gap after the last bit.
REQ-006 rd_clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  frame request, sampled only in IDLE.
REQ-009 data_in  input  DATA_W  packed pixels, LED k = data_in[24k+23:24k], each {R[23:16],G[15:8],B[7:0]}.
REQ-010 led_dout  output  1  serial WS2812 waveform to LED chain.
REQ-011 busy  output  1  high from frame latch until done.
REQ-012 done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 FSM states IDLE, BIT_HIGH, BIT_LOW, LATCH_GAP; encoding free.
REQ-014 IDLE with start=1 at edge N: data_in copied to internal shadow register, LED index=0, bit index=23, state->BIT_HIGH; at N+1 busy=1, led_dout=1.
REQ-015 data_in changes after edge N shall not affect the frame in progress.
REQ-016 start while busy=1 ignored; no queueing.
REQ-017 LED order: LED 0 first, ascending to NUM_LED-1; within an LED, 24 bits MSB first of the transmitted word (REQ-028/029).
REQ-018 Each bit occupies exactly TBIT_CYC cycles: led_dout=1 for T1H_CYC ('1') or T0H_CYC ('0') cycles, then 0 for the remainder.
REQ-019 Bit period counter counts 0..TBIT_CYC-1 and wraps; next bit's high phase begins the cycle after the wrap, with no idle gap between bits or between LEDs.
REQ-020 After bit 0 of LED NUM_LED-1: state->LATCH_GAP, led_dout=0 for TRST_CYC cycles.
REQ-021 Cycle after LATCH_GAP ends: done=1 for one cycle, busy=0 in that same cycle, state IDLE.
REQ-022 busy high duration = NUM_LED*24*TBIT_CYC + TRST_CYC cycles exactly.
REQ-023 start=1 on the done cycle is accepted (state is IDLE); back-to-back frames allowed.
REQ-024 Counters sized by $clog2 of their maximum; no overflow at NUM_LED*24 or TRST_CYC.
REQ-025 led_dout, busy, done shall be driven directly from flops (glitch-free).

Reset
REQ-026 rst_n low: state IDLE, led_dout=0, busy=0, done=0, all counters 0, shadow register 0, taking effect immediately without waiting for rd_clk.
REQ-027 rst_n asserted mid-frame aborts the frame; after release block waits in IDLE for a new start; no done pulse for the aborted frame.

Configuration
REQ-028 Macro WS2812_GRB_EN defined: each 24-bit word transmitted as {G,R,B} = {w[15:8],w[23:16],w[7:0]}, MSB first.
REQ-029 WS2812_GRB_EN undefined: each word transmitted unchanged {R,G,B}, bit 23 first; timing identical in both builds.

Verification (NUM_LED=2, T0H_CYC=2, T1H_CYC=4, TBIT_CYC=6, TRST_CYC=10 unless stated)
REQ-030 Reset then idle 20 cycles -> led_dout=0, busy=0, done=0 throughout.
REQ-031 GRB disabled, data_in={24'h000000,24'h800001}, start 1 cycle -> bit 0 high 4 cycles, bits 1..22 high 2 each, bit 23 high 4, LED1 all high 2; busy 298 cycles; done once.
REQ-032 GRB enabled, LED0=24'hFF0000 -> LED0 bits 0..7 high 2 cycles, bits 8..15 high 4, bits 16..23 high 2.
REQ-033 start pulsed again at cycle 50 of a frame, data_in changed -> ignored; waveform matches original data; single done.
REQ-034 rst_n low at cycle 100 of a frame -> led_dout=0, busy=0 asynchronously; no done; new start after release yields full correct frame.
REQ-035 start held high continuously -> frames back-to-back, done pulse every 299 cycles, led_dout low for exactly 11 cycles (10 gap + done cycle) between frames.
